// File: rtl/interrupt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_ctrl_pkg
// Shared types and constants for the interrupt controller:
//   - CPU register map (factor flags at 0xF00.., enable masks at 0xF10..)
//   - register index and interrupt vector index enums
//   - per-register valid-bit masks and save-state bus addresses
// ----------------------------------------------------------------------------
package interrupt_ctrl_pkg;

   localparam int          NUM_REGS       = 5;
   localparam int          NUM_VECTORS    = 15;
   localparam logic [11:0] ADDR_FLAG_BASE = 12'hF00;
   localparam logic [11:0] ADDR_MASK_BASE = 12'hF10;
   localparam logic [7:0]  SS_ADDR_FLAGS  = 8'h30;
   localparam logic [7:0]  SS_ADDR_MASKS  = 8'h31;

   // Offset of each register inside the flag block and the mask block.
   typedef enum logic [2:0] {
      REG_T  = 3'd0,
      REG_SW = 3'd1,
      REG_PT = 3'd2,
      REG_SR = 3'd3,
      REG_K0 = 3'd4
   } reg_idx_e;

   // Bit position of each source in interrupt_req.
   typedef enum logic [3:0] {
      IRQ_TIMER      = 4'd0,
      IRQ_STOPWATCH  = 4'd1,
      IRQ_PROG_TIMER = 4'd2,
      IRQ_K0         = 4'd3,
      IRQ_SERIAL     = 4'd4
   } irq_vec_e;

   // Implemented bits of each register nibble; the rest always read 0.
   // Packed index 4 is leftmost (REG_K0) down to index 0 (REG_T).
   localparam logic [NUM_REGS-1:0][3:0] FLAG_VALID = {4'h1, 4'h1, 4'h1, 4'h3, 4'hF};
   localparam logic [NUM_REGS-1:0][3:0] MASK_VALID = {4'hF, 4'h1, 4'h1, 4'h3, 4'hF};

   // True when addr selects one of the NUM_REGS registers of the block at base.
   function automatic logic reg_hit(input logic [11:0] addr, input logic [11:0] base);
      return (addr[11:4] == base[11:4]) && (addr[3:0] < 4'(NUM_REGS));
   endfunction

endpackage

// File: rtl/interrupt_ctrl_input_edge_detect.sv
// ----------------------------------------------------------------------------
// input_edge_detect
// Two-flop synchroniser for asynchronous button pins followed by a
// falling-edge detector. All flops advance only on clk_en edges so the
// detector runs at the CPU rate.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clk_en        CPU-rate enable
//   pins   [W]    raw asynchronous pin levels
//   fall   [W]    1 while a synchronised 1->0 transition is pending
// ----------------------------------------------------------------------------
module input_edge_detect #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clk_en,
   input  logic [W-1:0] pins,
   output logic [W-1:0] fall
);

   logic [W-1:0] sync1_q;
   logic [W-1:0] sync2_q;
   logic [W-1:0] prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour and the chain shifts by one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else if (clk_en) begin
         sync1_q <= pins;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// ----------------------------------------------------------------------------
// interrupt_ctrl
// Interrupt factor flags and enable masks for a 4-bit CPU. Source pulses set
// sticky factor flags; a CPU read of a flag register returns and clears it.
// interrupt_req is a pure combinational function of flags and masks.
// Ports:
//   clk, reset_n, clk_en          clock, async active-low reset, CPU-rate enable
//   timer_tick[4], stopwatch_tick[2], prog_timer_zero, serial_done  sources
//   input_k0[4]                   asynchronous button pins K00-K03
//   memory_*                      CPU register bus (read data is combinational)
//   interrupt_req[15]             per-vector request, bits [14:5] tied 0
//   ss_bus_*                      save-state access to flags (0x30) and masks (0x31)
// Configuration:
//   INTERRUPT_SAVESTATE_EN  when defined the ss_bus is live; otherwise
//                           ss_bus_out is 0 and ss_bus inputs are ignored.
// Save-state word layout: one nibble per register, [3:0]=T, [7:4]=SW,
//   [11:8]=PT, [15:12]=SR, [19:16]=K0. Whole nibbles are stored so a
//   save/restore round trip is bit-exact; logic uses only the valid bits.
// ----------------------------------------------------------------------------
module interrupt_ctrl
   import interrupt_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic [3:0]  timer_tick,
   input  logic [1:0]  stopwatch_tick,
   input  logic        prog_timer_zero,
   input  logic        serial_done,
   input  logic [3:0]  input_k0,
   input  logic [11:0] memory_addr,
   input  logic        memory_write_en,
   input  logic        memory_read_en,
   input  logic [3:0]  memory_write_data,
   output logic [3:0]  memory_read_data,
   output logic [NUM_VECTORS-1:0] interrupt_req,
   input  logic [31:0] ss_bus_in,
   input  logic [7:0]  ss_bus_addr,
   input  logic        ss_bus_wren,
   input  logic        ss_bus_reset_n,
   output logic [31:0] ss_bus_out
);

   logic [NUM_REGS-1:0][3:0] flag_q, flag_nxt, flag_v;
   logic [NUM_REGS-1:0][3:0] mask_q, mask_nxt, mask_v;
   logic [NUM_REGS-1:0][3:0] set;
   logic [3:0]               k0_fall;
   logic                     flag_hit;
   logic                     mask_hit;
   logic [2:0]               idx;

   input_edge_detect #(.W(4)) u_k0_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .pins    (input_k0),
      .fall    (k0_fall)
   );

   assign flag_hit = reg_hit(memory_addr, ADDR_FLAG_BASE);
   assign mask_hit = reg_hit(memory_addr, ADDR_MASK_BASE);
   assign idx      = memory_addr[2:0];

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      set                 = '0;
      set[REG_T]          = timer_tick;
      set[REG_SW][1:0]    = stopwatch_tick;
      set[REG_PT][0]      = prog_timer_zero;
      set[REG_SR][0]      = serial_done;
      set[REG_K0][0]      = |(k0_fall & mask_q[REG_K0]);
   end

   // Read-clear first, then OR in this cycle's pulse so a coincident
   // source event is never lost.
   always_comb begin
      flag_nxt = flag_q;
      mask_nxt = mask_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (memory_read_en && flag_hit && (idx == 3'(i)))
            flag_nxt[i] = '0;
         flag_nxt[i] = flag_nxt[i] | set[i];
         if (memory_write_en && mask_hit && (idx == 3'(i)))
            mask_nxt[i] = memory_write_data & MASK_VALID[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_q <= '0;
         mask_q <= '0;
      end else begin
`ifdef INTERRUPT_SAVESTATE_EN
         // Save-state access acts on any clk edge so state can be captured
         // or restored while the CPU is stalled (clk_en=0).
         if (!ss_bus_reset_n) begin
            flag_q <= '0;
            mask_q <= '0;
         end else if (ss_bus_wren && (ss_bus_addr == SS_ADDR_FLAGS)) begin
            flag_q <= ss_bus_in[19:0];
         end else if (ss_bus_wren && (ss_bus_addr == SS_ADDR_MASKS)) begin
            mask_q <= ss_bus_in[19:0];
         end else if (clk_en) begin
            flag_q <= flag_nxt;
            mask_q <= mask_nxt;
         end
`else
         if (clk_en) begin
            flag_q <= flag_nxt;
            mask_q <= mask_nxt;
         end
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         flag_v[i] = flag_q[i] & FLAG_VALID[i];
         mask_v[i] = mask_q[i] & MASK_VALID[i];
      end
   end

   always_comb begin
      memory_read_data = '0;
      if (memory_read_en) begin
         if (flag_hit)
            memory_read_data = flag_v[idx];
         else if (mask_hit)
            memory_read_data = mask_v[idx];
      end
   end

   // K0 is gated by EK0 at flag-set time, so its request is the flag alone.
   always_comb begin
      interrupt_req                 = '0;
      interrupt_req[IRQ_TIMER]      = |(flag_v[REG_T]  & mask_v[REG_T]);
      interrupt_req[IRQ_STOPWATCH]  = |(flag_v[REG_SW] & mask_v[REG_SW]);
      interrupt_req[IRQ_PROG_TIMER] = flag_v[REG_PT][0] & mask_v[REG_PT][0];
      interrupt_req[IRQ_K0]         = flag_v[REG_K0][0];
      interrupt_req[IRQ_SERIAL]     = flag_v[REG_SR][0] & mask_v[REG_SR][0];
   end

`ifdef INTERRUPT_SAVESTATE_EN
   always_comb begin
      ss_bus_out = '0;
      if (ss_bus_addr == SS_ADDR_FLAGS)
         ss_bus_out = 32'(flag_q);
      else if (ss_bus_addr == SS_ADDR_MASKS)
         ss_bus_out = 32'(mask_q);
   end
   logic unused_ss;
   assign unused_ss = ^ss_bus_in[31:20];
`else
   assign ss_bus_out = '0;
   logic unused_ss;
   assign unused_ss = ^{ss_bus_in, ss_bus_addr, ss_bus_wren, ss_bus_reset_n};
`endif

endmodule
